mac_acc: RTL and testbench
==========================

MAC_ACC -- requirements
Module: mac_acc

Interface
REQ-001 Parameter: LEN, 4, number of valid samples accumulated per result set; legal 1..16.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  begin new accumulation; honoured only in IDLE.
REQ-005 Port: in_valid  input  1  x_in/coef_in valid this cycle; honoured only in ACC.
REQ-006 Port: x_in  input  8  unsigned sample.
REQ-007 Port: coef_in  input  28  four unsigned 7-bit coefficients: [6:0] MU1, [13:7] MU2, [20:14] MU3, [27:21] MU4.
REQ-008 Port: busy  output  1  high in every state except IDLE.
REQ-009 Port: web  output  1  one-cycle write-back request to downstream wb stage.
REQ-010 Port: MU1..MU4  output  18 each  accumulator results, unsigned.

Function
REQ-011 States: IDLE, ACC, OUT, DRAIN; state, counters, accumulators registered; outputs driven from registers, no combinational path from inputs.
REQ-012 IDLE -> ACC on start=1; same edge clears MU1..MU4 and sample counter to 0.
REQ-013 In ACC, each cycle with in_valid=1 adds x_in*coef_k (15-bit product, zero-extended) to MUk for k=1..4 and increments sample counter.
REQ-014 ACC cycles with in_valid=0 change nothing; no timeout.
REQ-015 Edge registering the LEN-th valid sample moves ACC -> OUT; sample counter returns to 0.
REQ-016 OUT lasts exactly one cycle with web=1; MU1..MU4 already include the final product in that cycle.
REQ-017 OUT -> DRAIN; DRAIN lasts exactly 4 cycles, then -> IDLE; web=0 in all states except OUT.
REQ-018 MU1..MU4 hold final values from OUT through DRAIN and IDLE until the next accepted start (downstream captures MU2..MU4 at web and reads MU1 the following cycle).
REQ-019 start outside IDLE ignored; in_valid outside ACC ignored; start and in_valid high together in IDLE: only start honoured.
REQ-020 Accumulator overflow behaviour per REQ-025/026; LEN<=8 cannot overflow.

Reset
REQ-021 rst=0 forces immediately, regardless of clock: state IDLE, MU1..MU4=0, sample and drain counters 0, web=0, busy=0.
REQ-022 Reset mid-operation (any state) discards partial results; no web pulse after reset release until a new full sequence completes.
REQ-023 First start is accepted on the first rising edge with rst=1.

Configuration
REQ-024 Macro MAC_ACC_SAT_EN selects overflow handling.
REQ-025 MAC_ACC_SAT_EN defined: any addition whose true sum exceeds 18'h3FFFF sets that MUk to 18'h3FFFF; it stays saturated until cleared by start.
REQ-026 MAC_ACC_SAT_EN undefined: addition wraps modulo 2^18.

Verification
REQ-027 LEN=4, start at cycle 0, in_valid cycles 1-4 with x_in=1,2,3,4, coef_in fields MU1=1,MU2=2,MU3=3,MU4=4 -> web=1 only in cycle 5, MU1=10, MU2=20, MU3=30, MU4=40, busy low from cycle 10.
REQ-028 Same as REQ-027 with in_valid low on cycles 2 and 4 (samples on cycles 1,3,5,6) -> identical MU values, web only in cycle 7.
REQ-029 LEN=16, 16 samples x_in=255, all coefficients 127 -> MU1..MU4=18'h3FFFF with MAC_ACC_SAT_EN, 18'h3E810 (256016) without.
REQ-030 start pulsed in ACC, OUT and DRAIN -> ignored; MU values and web timing unchanged from REQ-027.
REQ-031 rst=0 asserted between clock edges during ACC after 2 samples -> outputs 0 immediately; after release, one full REQ-027 sequence gives REQ-027 results, exactly one web pulse.

Source files
------------

// File: rtl/mac_acc.sv
// mac_acc -- four-lane multiply-accumulate with a write-back handshake.
//
// One 8-bit unsigned sample x_in is multiplied by four 7-bit unsigned
// coefficients packed in coef_in, and each 15-bit product is accumulated
// into its own 18-bit lane (MU1..MU4). LEN valid samples form one result
// set. After the last sample, web pulses for one cycle (OUT). Four DRAIN
// cycles follow, and then the block returns to IDLE. Results hold until
// the next accepted start.
//
// Build option:
//   MAC_ACC_SAT_EN  defined   : lanes saturate at 18'h3FFFF
//                   undefined : lanes wrap modulo 2^18
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   start     begin a new accumulation (only looked at in IDLE)
//   in_valid  x_in/coef_in valid (only looked at in ACC)
//   x_in      [7:0]  unsigned sample
//   coef_in   [27:0] {MU4,MU3,MU2,MU1} 7-bit unsigned coefficients
//   busy      high in every state except IDLE
//   web       one-cycle write-back strobe (OUT state)
//   MU1..MU4  [17:0] lane accumulators

// Per-lane accumulator. It is cleared on clr and adds x*coef on en.
module mac_acc_lane #(
  parameter int VEC_W = 18,
  parameter int X_W   = 8,
  parameter int C_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [X_W-1:0]   x,
  input  logic [C_W-1:0]   coef,
  output logic [VEC_W-1:0] acc
);
  logic [X_W+C_W-1:0] prod;
  logic [VEC_W:0]     sum;
  logic [VEC_W-1:0]   acc_d, acc_q;

  always_comb begin
    prod  = {{C_W{1'b0}}, x} * {{X_W{1'b0}}, coef};
    // One extra bit so the carry out of the lane is visible.
    sum   = {1'b0, acc_q} + (VEC_W+1)'(prod);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
`ifdef MAC_ACC_SAT_EN
      // Once pinned at all-ones, any further add carries out again.
      // The lane therefore stays saturated until clr.
      acc_d = sum[VEC_W] ? '1 : sum[VEC_W-1:0];
`else
      acc_d = sum[VEC_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  assign acc = acc_q;
endmodule

module mac_acc #(
  parameter int LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  x_in,
  input  logic [27:0] coef_in,
  output logic        busy,
  output logic        web,
  output logic [17:0] MU1,
  output logic [17:0] MU2,
  output logic [17:0] MU3,
  output logic [17:0] MU4
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 18;
  localparam int X_W       = 8;
  localparam int C_W       = 7;
  localparam int CNT_W     = $clog2(LEN + 1);

  typedef enum logic [1:0] {IDLE, ACC, OUT, DRAIN} state_t;

  state_t                           state_d, state_q;
  logic [CNT_W-1:0]                 cnt_d, cnt_q;
  logic [1:0]                       drain_d, drain_q;
  logic                             web_d, web_q;
  logic                             busy_d, busy_q;
  logic                             clr, acc_en;
  logic [NUM_LANES-1:0][C_W-1:0]    coef;
  logic [NUM_LANES-1:0][VEC_W-1:0]  acc;

  assign coef   = coef_in;
  assign clr    = (state_q == IDLE) && start;
  assign acc_en = (state_q == ACC) && in_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
          cnt_d   = '0;
        end
      end
      ACC: begin
        if (in_valid) begin
          if (cnt_q == CNT_W'(LEN - 1)) begin
            state_d = OUT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      OUT: begin
        state_d = DRAIN;
        drain_d = '0;
      end
      DRAIN: begin
        if (drain_q == 2'd3) state_d = IDLE;
        else                 drain_d = drain_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Strobes are registered against the next state.
    // They then line up with the state they describe.
    web_d  = (state_d == OUT);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
      web_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      web_q   <= web_d;
      busy_q  <= busy_d;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mac_acc_lane #(.VEC_W(VEC_W), .X_W(X_W), .C_W(C_W)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .en   (acc_en),
      .x    (x_in),
      .coef (coef[i]),
      .acc  (acc[i])
    );
  end

  assign busy = busy_q;
  assign web  = web_q;
  assign MU1  = acc[0];
  assign MU2  = acc[1];
  assign MU3  = acc[2];
  assign MU4  = acc[3];
endmodule

// File: tb/tb_mac_acc.sv
// Scoreboarded bench for mac_acc: dut A (LEN=4) and dut B (LEN=16).
module tb_mac_acc;
  localparam int LEN_A = 4;
  localparam int LEN_B = 16;
  localparam longint LIM = 262143;
`ifdef MAC_ACC_SAT_EN
  localparam logic [17:0] EXP16 = 18'h3FFFF;
`else
  localparam logic [17:0] EXP16 = 18'h3E810;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a, inv_a, busy_a, web_a;
  logic [7:0] x_a;
  logic [27:0] coef_a;
  logic [17:0] mu_a1, mu_a2, mu_a3, mu_a4;
  logic start_b, inv_b, busy_b, web_b;
  logic [7:0] x_b;
  logic [27:0] coef_b;
  logic [17:0] mu_b1, mu_b2, mu_b3, mu_b4;

  mac_acc #(.LEN(LEN_A)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(inv_a), .x_in(x_a),
    .coef_in(coef_a), .busy(busy_a), .web(web_a),
    .MU1(mu_a1), .MU2(mu_a2), .MU3(mu_a3), .MU4(mu_a4));

  mac_acc #(.LEN(LEN_B)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(inv_b), .x_in(x_b),
    .coef_in(coef_b), .busy(busy_b), .web(web_b),
    .MU1(mu_b1), .MU2(mu_b2), .MU3(mu_b3), .MU4(mu_b4));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int                 cyc;
    logic [3:0][17:0]   mu;
  } exp_t;

  exp_t        q[2][$];
  bit          mu1_pend[2];
  logic [17:0] mu1_exp[2];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model for one lane addition, using the arithmetic the spec describes.
  function automatic longint acc_step(input longint s, input longint p);
    longint t;
    t = s + p;
`ifdef MAC_ACC_SAT_EN
    if (t > LIM) t = LIM;
`endif
    return t;
  endfunction

  // Monitor: whenever web is seen, pop the next expected result set.
  task automatic mon(input int id, input logic w, input logic [3:0][17:0] mu);
    exp_t e;
    if (w) begin
      if (q[id].size() == 0) begin
        chk($sformatf("web_unexpected_%0d", id), w, 0);
      end else begin
        e = q[id].pop_front();
        chk($sformatf("web_cycle_%0d", id), cyc, e.cyc);
        for (int k = 0; k < 4; k++)
          chk($sformatf("MU%0d_at_web_%0d", k + 1, id), mu[k], e.mu[k]);
        mu1_pend[id] = 1'b1;
        mu1_exp[id]  = e.mu[0];
      end
    end else if (mu1_pend[id]) begin
      chk($sformatf("MU1_after_web_%0d", id), mu[0], mu1_exp[id]);
      mu1_pend[id] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon(0, web_a, {mu_a4, mu_a3, mu_a2, mu_a1});
      mon(1, web_b, {mu_b4, mu_b3, mu_b2, mu_b1});
    end else begin
      mu1_pend[0] = 1'b0;
      mu1_pend[1] = 1'b0;
    end
  end

  // One result set on dut A. Expected results are pushed when the final sample is issued.
  task automatic run_seq(input bit directed, input bit [15:0] vpat, input bit noisy,
                         input bit do_start);
    longint s[4];
    int     n, c;
    bit     v;
    exp_t   e;
    for (int k = 0; k < 4; k++) s[k] = 0;
    n = 0;
    c = 0;
    if (do_start) begin
      // Valid data in IDLE without start must be ignored.
      start_a = 1'b0; inv_a = 1'b1; x_a = 8'($urandom); coef_a = 28'($urandom);
      tick();
      chk("idle_ignores_valid", busy_a, 0);
      start_a = 1'b1; inv_a = 1'($urandom_range(0, 1));
      x_a = 8'($urandom); coef_a = 28'($urandom);
      tick();
    end
    while (n < LEN_A) begin
      if (c == 0) chk("busy_in_acc", busy_a, 1);
      v = directed ? vpat[c] : (c > 40 || $urandom_range(0, 99) < 70);
      start_a = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      inv_a = v;
      if (directed) begin
        x_a = 8'(n + 1);
        coef_a = {7'd4, 7'd3, 7'd2, 7'd1};
      end else begin
        x_a = 8'($urandom);
        coef_a = 28'($urandom);
      end
      if (v) begin
        for (int k = 0; k < 4; k++)
          s[k] = acc_step(s[k], longint'(x_a) * longint'(coef_a[7*k +: 7]));
        n++;
        if (n == LEN_A) begin
          e.cyc = cyc + 1;
          for (int k = 0; k < 4; k++) e.mu[k] = s[k][17:0];
          q[0].push_back(e);
        end
      end
      c++;
      tick();
    end
    // OUT and DRAIN: stray start/valid must change nothing.
    for (int i = 0; i < 5; i++) begin
      start_a = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      inv_a = 1'($urandom_range(0, 1)); x_a = 8'($urandom); coef_a = 28'($urandom);
      if (i == 4) chk("busy_last_drain", busy_a, 1);
      tick();
    end
    start_a = 1'b0;
    inv_a = 1'b0;
    chk("idle_after_drain", busy_a, 0);
  endtask

  task automatic run_b(input bit rnd);
    longint s[4];
    exp_t   e;
    for (int k = 0; k < 4; k++) s[k] = 0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int n = 0; n < LEN_B; n++) begin
      inv_b = 1'b1;
      x_b = rnd ? 8'($urandom) : 8'hFF;
      coef_b = rnd ? 28'($urandom) : {4{7'h7F}};
      for (int k = 0; k < 4; k++)
        s[k] = acc_step(s[k], longint'(x_b) * longint'(coef_b[7*k +: 7]));
      if (n == LEN_B - 1) begin
        e.cyc = cyc + 1;
        for (int k = 0; k < 4; k++) e.mu[k] = s[k][17:0];
        q[1].push_back(e);
      end
      tick();
    end
    inv_b = 1'b0;
    repeat (5) tick();
    chk("b_idle_after_drain", busy_b, 0);
    if (!rnd) begin
      chk("b_limit_MU1", mu_b1, EXP16);
      chk("b_limit_MU2", mu_b2, EXP16);
      chk("b_limit_MU3", mu_b3, EXP16);
      chk("b_limit_MU4", mu_b4, EXP16);
    end
  endtask

  task automatic chk_const(input string tag);
    chk({tag, "_MU1"}, mu_a1, 10);
    chk({tag, "_MU2"}, mu_a2, 20);
    chk({tag, "_MU3"}, mu_a3, 30);
    chk({tag, "_MU4"}, mu_a4, 40);
  endtask

  initial begin
    start_a = 0; inv_a = 0; x_a = 0; coef_a = 0;
    start_b = 0; inv_b = 0; x_b = 0; coef_b = 0;
    mu1_pend[0] = 0; mu1_pend[1] = 0;
    tick();
    tick();
    chk("rst_busy", busy_a, 0);
    chk("rst_web", web_a, 0);
    chk("rst_MU1", mu_a1, 0);
    chk("rst_MU4", mu_a4, 0);
    chk("rst_b_busy", busy_b, 0);
    rst = 1'b1;

    // Four contiguous samples.
    run_seq(1'b1, 16'hFFFF, 1'b0, 1'b1);
    chk_const("contig");
    // Gaps: samples land in ACC cycles 0,2,4,5.
    run_seq(1'b1, 16'b110101, 1'b0, 1'b1);
    chk_const("gapped");
    // Start pulses during ACC/OUT/DRAIN.
    run_seq(1'b1, 16'hFFFF, 1'b1, 1'b1);
    chk_const("start_noise");

    // Async reset between edges after two samples.
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int n = 0; n < 2; n++) begin
      inv_a = 1'b1; x_a = 8'(n + 1); coef_a = {7'd4, 7'd3, 7'd2, 7'd1};
      tick();
    end
    inv_a = 1'b0;
    chk("pre_rst_MU1", mu_a1, 3);
    chk("pre_rst_MU4", mu_a4, 12);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_MU1", mu_a1, 0);
    chk("async_rst_MU2", mu_a2, 0);
    chk("async_rst_MU3", mu_a3, 0);
    chk("async_rst_MU4", mu_a4, 0);
    chk("async_rst_busy", busy_a, 0);
    chk("async_rst_web", web_a, 0);
    tick();
    #3 rst = 1'b1;
    start_a = 1'b1;
    tick();
    chk("first_start_after_rst", busy_a, 1);
    run_seq(1'b1, 16'hFFFF, 1'b0, 1'b0);
    chk_const("after_rst");

    // Randomized result sets.
    repeat (20) run_seq(1'b0, 16'h0, 1'($urandom_range(0, 1)), 1'b1);

    // LEN=16 full-scale, then random.
    run_b(1'b0);
    run_b(1'b1);
    run_b(1'b1);

    repeat (3) tick();
    chk("scoreboard_empty_a", q[0].size(), 0);
    chk("scoreboard_empty_b", q[1].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
